// File: rtl/ifu_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Holds the FSM state encoding, the PC-select encoding and the reset constants.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_pc.sv
// Program counter register with its next-PC mux (hold, +4 or redirect target).
// The +4 path wraps modulo 2^32; redirect targets are forced word-aligned.
module ifu_fetch_pc
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_sel_e     pc_sel,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_q
);

    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            PC_INC:      pc_d = pc_q + 32'd4;
            PC_REDIRECT: pc_d = word_align(redirect_pc);
            default:     pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: one outstanding req/gnt/rvalid transaction at a time and a
// holding register that presents the fetched word to decode.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic         cpu_clk,
    input  logic         cpu_rst,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [31:0]  inst,
    output logic [31:0]  inst_pc,
    output logic [31:0]  inst_pc4,
    output fetch_state_e dbg_state
);

    // Handshake: an instruction transfers on a cycle where inst_valid & inst_ready & !redirect;
    // once raised, inst_valid and the held fields stay stable until that transfer or a redirect.

    fetch_state_e state_q, state_d;
    pc_sel_e      pc_sel;
    logic         load_inst;
    logic [31:0]  pc_q;

    ifu_fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (cpu_clk),
        .rst         (cpu_rst),
        .pc_sel      (pc_sel),
        .redirect_pc (redirect_pc),
        .pc_q        (pc_q)
    );

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect wins over every other event in every state.
    always_comb begin
        state_d   = state_q;
        pc_sel    = PC_HOLD;
        load_inst = 1'b0;
        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_sel  = PC_REDIRECT;
                    state_d = imem_gnt ? S_DROP : S_REQ;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_sel  = PC_REDIRECT;
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    pc_sel    = PC_INC;
                    load_inst = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_sel = PC_REDIRECT;
                end
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_sel  = PC_REDIRECT;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            inst_pc    <= 32'h0;
            inst_pc4   <= 32'h0;
        end else begin
            inst_valid <= (state_d == S_HOLD);
            if (load_inst) begin
                inst     <= imem_rdata;
                inst_pc  <= pc_q;
                inst_pc4 <= pc_q + 32'd4;
            end
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign dbg_state = state_q;

    no_stray_rvalid: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
        imem_rvalid |-> (state_q == S_WAIT || state_q == S_DROP));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a driver plays the memory and decode sides while a
// monitor pops expected {inst, inst_pc, inst_pc4} entries whenever decode consumes.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic         cpu_clk = 1'b0;
    logic         cpu_rst = 1'b1;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_gnt = 1'b0;
    logic         imem_rvalid = 1'b0;
    logic [31:0]  imem_rdata = 32'h0;
    logic         redirect = 1'b0;
    logic [31:0]  redirect_pc = 32'h0;
    logic         inst_valid;
    logic         inst_ready = 1'b0;
    logic [31:0]  inst;
    logic [31:0]  inst_pc;
    logic [31:0]  inst_pc4;
    fetch_state_e dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [95:0] exp_q[$];

    ifu_fetch dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_pc4    (inst_pc4),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    always #5 cpu_clk = ~cpu_clk;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a consume is valid & ready & !redirect.
    always @(negedge cpu_clk) begin
        if (!cpu_rst && inst_valid && inst_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_inst: got %08h@%08h expected none", inst, inst_pc);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                check("mon_inst", inst, e[95:64]);
                check("mon_inst_pc", inst_pc, e[63:32]);
                check("mon_inst_pc4", inst_pc4, e[31:0]);
            end
        end
    end

    // Driver: request at exp_addr granted at once, data returned one cycle later.
    // Ends one cycle after rvalid (S_HOLD when the word was kept).
    task automatic fetch_word(input logic [31:0] exp_addr, input logic [31:0] data,
                              input logic keep);
        check("req_before_gnt", {31'b0, imem_req}, 32'd1);
        check("req_addr", imem_addr, exp_addr);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        if (keep) exp_q.push_back({data, exp_addr, exp_addr + 32'd4});
        tick();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_req", {31'b0, imem_req}, 32'd1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_pc4", inst_pc4, 32'h0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        cpu_rst = 1'b0;

        // 1: first fetch after reset, decode ready
        inst_ready = 1'b1;
        fetch_word(32'h0, 32'h0050_0093, 1'b1);
        check("t1_valid", {31'b0, inst_valid}, 32'd1);
        tick();
        check("t1_next_addr", imem_addr, 32'h4);
        check("t1_next_req", {31'b0, imem_req}, 32'd1);

        // 2: decode stalls five cycles
        inst_ready = 1'b0;
        fetch_word(32'h4, 32'h00a0_0113, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t2_valid", {31'b0, inst_valid}, 32'd1);
            check("t2_inst", inst, 32'h00a0_0113);
            check("t2_inst_pc", inst_pc, 32'h4);
            check("t2_inst_pc4", inst_pc4, 32'h8);
            check("t2_req", {31'b0, imem_req}, 32'd0);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        check("t2_next_addr", imem_addr, 32'h8);

        // 3: redirect while waiting, stale data two cycles later
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        check("t3_drop_req", {31'b0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hdead_beef;
        check("t3_valid_drop", {31'b0, inst_valid}, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        check("t3_valid_after", {31'b0, inst_valid}, 32'd0);
        check("t3_inst_kept", inst, 32'h00a0_0113);
        check("t3_next_addr", imem_addr, 32'h100);
        check("t3_next_req", {31'b0, imem_req}, 32'd1);

        // 4: redirect without gnt to 0x8, then redirect coincident with gnt to 0x40
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0008;
        tick();
        check("t4_addr8", imem_addr, 32'h8);
        check("t4_still_req", {31'b0, imem_req}, 32'd1);
        imem_gnt    = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        imem_gnt = 1'b0;
        redirect = 1'b0;
        check("t4_drop_req", {31'b0, imem_req}, 32'd0);
        check("t4_drop_addr", imem_addr, 32'h40);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        tick();
        imem_rvalid = 1'b0;
        check("t4_valid_drop", {31'b0, inst_valid}, 32'd0);
        fetch_word(32'h40, 32'h0000_0297, 1'b1);
        tick();
        check("t4_next_addr", imem_addr, 32'h44);

        // 5: redirect with ready in S_HOLD drops the held word
        fetch_word(32'h44, 32'h1234_5678, 1'b0);
        check("t5_held", {31'b0, inst_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        check("t5_valid", {31'b0, inst_valid}, 32'd0);
        check("t5_addr", imem_addr, 32'h200);
        check("t5_req", {31'b0, imem_req}, 32'd1);

        // 6: asynchronous reset mid-wait, then PC wrap
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #2;
        cpu_rst = 1'b1;
        #1;
        check("t6_inst", inst, 32'h0000_0013);
        check("t6_inst_pc", inst_pc, 32'h0);
        check("t6_inst_pc4", inst_pc4, 32'h0);
        check("t6_req", {31'b0, imem_req}, 32'd1);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_state", {30'b0, dbg_state}, 32'd0);
        cpu_rst = 1'b0;
        tick();
        fetch_word(32'h0, 32'h0000_0033, 1'b1);
        tick();
        check("t6_next_addr", imem_addr, 32'h4);
        redirect    = 1'b1;
        redirect_pc = 32'hffff_fffc;
        tick();
        redirect = 1'b0;
        fetch_word(32'hffff_fffc, 32'h0000_006f, 1'b1);
        tick();
        check("t6_wrap_addr", imem_addr, 32'h0);

        tick();
        check("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
